// File: rtl/narrow_axi_init_master_if.sv
// Command/response stream plus single-beat AXI4 bus of narrow_axi_init_master.
// master: the manager side (the design); slave: the command source and AXI subordinate.
interface narrow_axi_init_master_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic                 cmd_write_i;
    logic [AddrWidth-1:0] cmd_addr_i;
    logic [DataWidth-1:0] cmd_data_i;
    logic [StrbWidth-1:0] cmd_strb_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_data_o;
    logic [1:0]           rsp_resp_o;

    logic                 aw_valid_o;
    logic                 aw_ready_i;
    logic [AddrWidth-1:0] aw_addr_o;

    logic                 w_valid_o;
    logic                 w_ready_i;
    logic [DataWidth-1:0] w_data_o;
    logic [StrbWidth-1:0] w_strb_o;
    logic                 w_last_o;

    logic                 b_valid_i;
    logic                 b_ready_o;
    logic [1:0]           b_resp_i;

    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [AddrWidth-1:0] ar_addr_o;

    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [DataWidth-1:0] r_data_i;
    logic [1:0]           r_resp_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_data_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_resp_o,
        input  rsp_ready_i,
        output aw_valid_o, aw_addr_o,
        input  aw_ready_i,
        output w_valid_o, w_data_o, w_strb_o, w_last_o,
        input  w_ready_i,
        input  b_valid_i, b_resp_i,
        output b_ready_o,
        output ar_valid_o, ar_addr_o,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_resp_i,
        output r_ready_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_data_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_resp_o,
        output rsp_ready_i,
        input  aw_valid_o, aw_addr_o,
        output aw_ready_i,
        input  w_valid_o, w_data_o, w_strb_o, w_last_o,
        output w_ready_i,
        output b_valid_i, b_resp_i,
        input  b_ready_o,
        input  ar_valid_o, ar_addr_o,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_resp_i,
        input  r_ready_o
    );
endinterface

// File: rtl/narrow_axi_init_master.sv
// Single-outstanding AXI4 manager: turns a read/write command stream into
// single-beat AXI4 transactions and returns one response per command.
// Optional macro NARROW_AXI_INIT_TIMEOUT_EN: abort a B/R wait after
// TimeoutCycles cycles with an SLVERR response.
module narrow_axi_init_master #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input logic                       clk_i,
    input logic                       rst_i,
    narrow_axi_init_master_if.master  bus
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    // Reject a zero timeout at elaboration; the abort path needs at least one wait cycle.
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, WR, WB, RD, RR, RSP} state_e;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 aw_valid_q, aw_valid_d;
    logic                 w_valid_q, w_valid_d;
    logic                 b_ready_q, b_ready_d;
    logic                 ar_valid_q, ar_valid_d;
    logic                 r_ready_q, r_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;
    logic                 timeout_c;

`ifdef NARROW_AXI_INIT_TIMEOUT_EN
    localparam int unsigned TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [TimerWidth-1:0] timer_q, timer_d;

    // Wait-cycle counter: zero outside WB/RR, so it restarts on every entry.
    always_comb begin
        timer_d = '0;
        if (state_q == WB || state_q == RR) begin
            timer_d = timer_q + TimerWidth'(1);
        end
    end

    // Timer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout_c = (timer_q == TimerWidth'(TimeoutCycles - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next-output logic; every output is a flop loaded from here.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr_i;
                    data_d      = bus.cmd_data_i;
                    strb_d      = bus.cmd_strb_i;
                    if (bus.cmd_write_i) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            WR: begin
                // The valid flops double as the not-yet-sent flags for AW and W.
                if (aw_valid_q && bus.aw_ready_i) begin
                    aw_valid_d = 1'b0;
                end
                if (w_valid_q && bus.w_ready_i) begin
                    w_valid_d = 1'b0;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WB;
                end
            end
            WB: begin
                if (b_ready_q && bus.b_valid_i) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = bus.b_resp_i;
                    state_d     = RSP;
                end else if (timeout_c) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = 2'd2;
                    state_d     = RSP;
                end
            end
            RD: begin
                if (ar_valid_q && bus.ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RR;
                end
            end
            RR: begin
                if (r_ready_q && bus.r_valid_i) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.r_data_i;
                    rsp_resp_d  = bus.r_resp_i;
                    state_d     = RSP;
                end else if (timeout_c) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = 2'd2;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.aw_valid_o  = aw_valid_q;
    assign bus.aw_addr_o   = addr_q;
    assign bus.w_valid_o   = w_valid_q;
    assign bus.w_data_o    = data_q;
    assign bus.w_strb_o    = strb_q;
    assign bus.w_last_o    = w_valid_q;
    assign bus.b_ready_o   = b_ready_q;
    assign bus.ar_valid_o  = ar_valid_q;
    assign bus.ar_addr_o   = addr_q;
    assign bus.r_ready_o   = r_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_resp_o  = rsp_resp_q;
endmodule
